// File: rtl/mux_pkg.sv
// Shared constants and the select-mode encoding for the channel arbiter.
package mux_pkg;

  typedef enum logic {
    MODE_SELECT      = 1'b0,
    MODE_ROUND_ROBIN = 1'b1
  } mode_e;

  localparam int DEFAULT_BITS     = 32;
  localparam int DEFAULT_CHANNELS = 8;
  localparam int MAX_CHANNELS     = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin nominee search: first requester at or above the pointer, with wrap.
module rr_picker #(
  parameter  int CHANNELS = 8,
  localparam int SEL_BITS = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [SEL_BITS-1:0] i_ptr,
  output logic                o_found,
  output logic [SEL_BITS-1:0] o_idx
);

  logic [SEL_BITS:0]   w_cand;
  logic [SEL_BITS-1:0] w_cand_idx;

  // Scan offsets high to low so the smallest offset from the pointer wins.
  always_comb begin
    o_found    = 1'b0;
    o_idx      = '0;
    w_cand     = '0;
    w_cand_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      w_cand = {1'b0, i_ptr} + (SEL_BITS + 1)'(i);
      if (w_cand >= (SEL_BITS + 1)'(CHANNELS)) begin
        w_cand = w_cand - (SEL_BITS + 1)'(CHANNELS);
      end
      w_cand_idx = SEL_BITS'(w_cand);
      if (i_req[w_cand_idx]) begin
        o_found = 1'b1;
        o_idx   = w_cand_idx;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// N-channel to one registered output arbiter with direct-select or round-robin nomination.
module mux_arbiter
  import mux_pkg::*;
#(
  parameter  int BITS     = DEFAULT_BITS,
  parameter  int CHANNELS = DEFAULT_CHANNELS,
  localparam int SEL_BITS = $clog2(CHANNELS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNELS*BITS-1:0] datoIn,
  input  logic [CHANNELS-1:0]      validIn,
  output logic [CHANNELS-1:0]      readyOut,
  input  logic                     selMode,
  input  logic [SEL_BITS-1:0]      selDato,
  output logic [BITS-1:0]          datoOutput,
  output logic                     validOutput,
  input  logic                     readyInput,
  output logic [SEL_BITS-1:0]      grantOutput
);

  logic [BITS-1:0]     r_data;
  logic                r_valid;
  logic [SEL_BITS-1:0] r_grant;
  logic [SEL_BITS-1:0] r_ptr;

  logic                    w_accept;
  logic                    w_rr_mode;
  logic                    w_rr_found;
  logic [SEL_BITS-1:0]     w_rr_idx;
  logic [MAX_CHANNELS-1:0] w_valid_pad;
  logic                    w_dir_found;
  logic                    w_nom_found;
  logic [SEL_BITS-1:0]     w_nom_idx;
  logic                    w_xfer;
  logic [SEL_BITS-1:0]     w_ptr_next;
  logic [BITS-1:0]         w_chan [CHANNELS];

  rr_picker #(
    .CHANNELS (CHANNELS)
  ) u_rr_picker (
    .i_req   (validIn),
    .i_ptr   (r_ptr),
    .o_found (w_rr_found),
    .o_idx   (w_rr_idx)
  );

  assign w_accept  = ~r_valid | readyInput;
  assign w_rr_mode = (mode_e'(selMode) == MODE_ROUND_ROBIN);

  // Zero-padded valid vector makes out-of-range selDato values naturally nominate nothing.
  assign w_valid_pad = MAX_CHANNELS'(validIn);
  assign w_dir_found = w_valid_pad[4'(selDato)];

  assign w_nom_found = w_rr_mode ? w_rr_found : w_dir_found;
  assign w_nom_idx   = w_rr_mode ? w_rr_idx : selDato;
  assign w_xfer      = ~reset & w_accept & w_nom_found;
  assign w_ptr_next  = (w_nom_idx == SEL_BITS'(CHANNELS - 1)) ? '0 : w_nom_idx + SEL_BITS'(1);

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      w_chan[k] = datoIn[k*BITS +: BITS];
    end
  end

  always_comb begin
    readyOut = '0;
    if (w_xfer) begin
      readyOut[w_nom_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_grant <= '0;
      r_ptr   <= '0;
    end else if (w_accept) begin
      r_valid <= w_nom_found;
      if (w_nom_found) begin
        r_data  <= w_chan[w_nom_idx];
        r_grant <= w_nom_idx;
        if (w_rr_mode) begin
          r_ptr <= w_ptr_next;
        end
      end
    end
  end

  assign datoOutput  = r_data;
  assign validOutput = r_valid;
  assign grantOutput = r_grant;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: an 8-channel and a 6-channel instance share clock and reset.
module tb_mux_arbiter;

  logic         clk;
  logic         reset;

  logic [255:0] din8;
  logic [7:0]   vin8;
  logic [7:0]   rdy8;
  logic         mode8;
  logic [2:0]   sel8;
  logic [31:0]  dout8;
  logic         vout8;
  logic         rin8;
  logic [2:0]   gnt8;

  logic [191:0] din6;
  logic [5:0]   vin6;
  logic [5:0]   rdy6;
  logic         mode6;
  logic [2:0]   sel6;
  logic [31:0]  dout6;
  logic         vout6;
  logic         rin6;
  logic [2:0]   gnt6;

  int errors;
  int checks;

  mux_arbiter u_dut8 (
    .clk         (clk),
    .reset       (reset),
    .datoIn      (din8),
    .validIn     (vin8),
    .readyOut    (rdy8),
    .selMode     (mode8),
    .selDato     (sel8),
    .datoOutput  (dout8),
    .validOutput (vout8),
    .readyInput  (rin8),
    .grantOutput (gnt8)
  );

  mux_arbiter #(
    .BITS     (32),
    .CHANNELS (6)
  ) u_dut6 (
    .clk         (clk),
    .reset       (reset),
    .datoIn      (din6),
    .validIn     (vin6),
    .readyOut    (rdy6),
    .selMode     (mode6),
    .selDato     (sel6),
    .datoOutput  (dout6),
    .validOutput (vout6),
    .readyInput  (rin6),
    .grantOutput (gnt6)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_data();
    for (int k = 0; k < 8; k++) din8[k*32 +: 32] = 32'hA5A5_0000 | 32'(k);
    for (int k = 0; k < 6; k++) din6[k*32 +: 32] = 32'hC6C6_0000 | 32'(k);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vin8 = 8'hFF; rin8 = 1'b1; mode8 = 1'b0; sel8 = 3'd5;
    vin6 = 6'h3F; rin6 = 1'b1; mode6 = 1'b0; sel6 = 3'd1;
    #1;
    checks++;
    if (rdy8 !== 8'h00) begin
      errors++; $display("FAIL reset_ready8: got %h expected %h", rdy8, 8'h00);
    end
    checks++;
    if (rdy6 !== 6'h00) begin
      errors++; $display("FAIL reset_ready6: got %h expected %h", rdy6, 6'h00);
    end
    tick();
    tick();
    checks++;
    if (vout8 !== 1'b0 || dout8 !== 32'h0 || gnt8 !== 3'd0) begin
      errors++;
      $display("FAIL reset_out8: got v=%b d=%h g=%0d expected v=0 d=0 g=0", vout8, dout8, gnt8);
    end
    checks++;
    if (vout6 !== 1'b0 || dout6 !== 32'h0 || gnt6 !== 3'd0) begin
      errors++;
      $display("FAIL reset_out6: got v=%b d=%h g=%0d expected v=0 d=0 g=0", vout6, dout6, gnt6);
    end
    reset = 1'b0;
    vin8 = 8'h00;
    vin6 = 6'h00;
    #1;
  endtask

  task automatic test_direct();
    mode8 = 1'b0; sel8 = 3'd5; vin8 = 8'hFF; rin8 = 1'b1;
    #1;
    checks++;
    if (rdy8 !== 8'h20) begin
      errors++; $display("FAIL direct_ready: got %h expected %h", rdy8, 8'h20);
    end
    tick();
    checks++;
    if (dout8 !== 32'hA5A5_0005 || gnt8 !== 3'd5 || vout8 !== 1'b1) begin
      errors++;
      $display("FAIL direct_out: got d=%h g=%0d v=%b expected d=a5a50005 g=5 v=1",
               dout8, gnt8, vout8);
    end
    // Selected channel idle: output drains, word and grant hold.
    vin8 = 8'hDF;
    #1;
    checks++;
    if (rdy8 !== 8'h00) begin
      errors++; $display("FAIL direct_idle_ready: got %h expected %h", rdy8, 8'h00);
    end
    tick();
    checks++;
    if (vout8 !== 1'b0 || dout8 !== 32'hA5A5_0005 || gnt8 !== 3'd5) begin
      errors++;
      $display("FAIL direct_idle_out: got v=%b d=%h g=%0d expected v=0 d=a5a50005 g=5",
               vout8, dout8, gnt8);
    end
  endtask

  task automatic test_stall();
    mode8 = 1'b0; sel8 = 3'd3; vin8 = 8'hFF; rin8 = 1'b1;
    din8[3*32 +: 32] = 32'h0000_1234;
    tick();
    checks++;
    if (dout8 !== 32'h0000_1234 || vout8 !== 1'b1 || gnt8 !== 3'd3) begin
      errors++;
      $display("FAIL stall_load: got d=%h v=%b g=%0d expected d=00001234 v=1 g=3",
               dout8, vout8, gnt8);
    end
    rin8 = 1'b0;
    sel8 = 3'd4;
    din8[3*32 +: 32] = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rdy8 !== 8'h00) begin
        errors++; $display("FAIL stall_ready[%0d]: got %h expected %h", i, rdy8, 8'h00);
      end
      tick();
      checks++;
      if (dout8 !== 32'h0000_1234 || vout8 !== 1'b1 || gnt8 !== 3'd3) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got d=%h v=%b g=%0d expected d=00001234 v=1 g=3",
                 i, dout8, vout8, gnt8);
      end
    end
    rin8 = 1'b1;
    #1;
    checks++;
    if (rdy8 !== 8'h10) begin
      errors++; $display("FAIL stall_release_ready: got %h expected %h", rdy8, 8'h10);
    end
    tick();
    checks++;
    if (dout8 !== 32'hA5A5_0004 || gnt8 !== 3'd4 || vout8 !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_out: got d=%h g=%0d v=%b expected d=a5a50004 g=4 v=1",
               dout8, gnt8, vout8);
    end
    load_data();
  endtask

  task automatic test_rr_sequence();
    int exp;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mode8 = 1'b1; vin8 = 8'hFF; rin8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp = i % 8;
      tick();
      checks++;
      if (gnt8 !== 3'(exp) || dout8 !== (32'hA5A5_0000 | 32'(exp)) || vout8 !== 1'b1) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got g=%0d d=%h v=%b expected g=%0d d=%h v=1",
                 i, gnt8, dout8, vout8, exp, 32'hA5A5_0000 | 32'(exp));
      end
    end
  endtask

  task automatic test_rr_wrap();
    logic [2:0] exp [3];
    exp[0] = 3'd7; exp[1] = 3'd0; exp[2] = 3'd7;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mode8 = 1'b1; vin8 = 8'h01; rin8 = 1'b1;
    tick();
    checks++;
    if (gnt8 !== 3'd0 || vout8 !== 1'b1) begin
      errors++; $display("FAIL rr_wrap_setup: got g=%0d v=%b expected g=0 v=1", gnt8, vout8);
    end
    vin8 = 8'h81;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (gnt8 !== exp[i] || vout8 !== 1'b1) begin
        errors++;
        $display("FAIL rr_wrap[%0d]: got g=%0d v=%b expected g=%0d v=1", i, gnt8, vout8, exp[i]);
      end
    end
  endtask

  task automatic test_range6();
    mode6 = 1'b0; sel6 = 3'd2; vin6 = 6'h3F; rin6 = 1'b1;
    #1;
    checks++;
    if (rdy6 !== 6'h04) begin
      errors++; $display("FAIL range6_ready: got %h expected %h", rdy6, 6'h04);
    end
    tick();
    checks++;
    if (vout6 !== 1'b1 || gnt6 !== 3'd2 || dout6 !== 32'hC6C6_0002) begin
      errors++;
      $display("FAIL range6_load: got v=%b g=%0d d=%h expected v=1 g=2 d=c6c60002",
               vout6, gnt6, dout6);
    end
    sel6 = 3'd6;
    #1;
    checks++;
    if (rdy6 !== 6'h00) begin
      errors++; $display("FAIL range6_sel6_ready: got %h expected %h", rdy6, 6'h00);
    end
    sel6 = 3'd7;
    #1;
    checks++;
    if (rdy6 !== 6'h00) begin
      errors++; $display("FAIL range6_sel7_ready: got %h expected %h", rdy6, 6'h00);
    end
    tick();
    checks++;
    if (vout6 !== 1'b0 || gnt6 !== 3'd2 || dout6 !== 32'hC6C6_0002) begin
      errors++;
      $display("FAIL range6_drain: got v=%b g=%0d d=%h expected v=0 g=2 d=c6c60002",
               vout6, gnt6, dout6);
    end
    vin6 = 6'h00;
  endtask

  task automatic test_reset_mid_stall();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mode8 = 1'b1; vin8 = 8'hFF; rin8 = 1'b1;
    tick();
    tick();
    tick();
    rin8 = 1'b0;
    tick();
    checks++;
    if (vout8 !== 1'b1 || gnt8 !== 3'd2 || dout8 !== 32'hA5A5_0002) begin
      errors++;
      $display("FAIL midstall_hold: got v=%b g=%0d d=%h expected v=1 g=2 d=a5a50002",
               vout8, gnt8, dout8);
    end
    reset = 1'b1;
    rin8 = 1'b1;
    #1;
    checks++;
    if (rdy8 !== 8'h00) begin
      errors++; $display("FAIL midstall_reset_ready: got %h expected %h", rdy8, 8'h00);
    end
    tick();
    checks++;
    if (vout8 !== 1'b0 || dout8 !== 32'h0 || gnt8 !== 3'd0) begin
      errors++;
      $display("FAIL midstall_reset_out: got v=%b d=%h g=%0d expected v=0 d=0 g=0",
               vout8, dout8, gnt8);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (vout8 !== 1'b1 || gnt8 !== 3'd0 || dout8 !== 32'hA5A5_0000) begin
      errors++;
      $display("FAIL midstall_first_grant: got v=%b g=%0d d=%h expected v=1 g=0 d=a5a50000",
               vout8, gnt8, dout8);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clk = 1'b0;
    reset = 1'b1;
    din8 = '0; vin8 = '0; mode8 = 1'b0; sel8 = '0; rin8 = 1'b0;
    din6 = '0; vin6 = '0; mode6 = 1'b0; sel6 = '0; rin6 = 1'b0;
    load_data();
    tick();
    test_reset();
    test_direct();
    test_stall();
    test_rr_sequence();
    test_rr_wrap();
    test_range6();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have parameter BITS, default 32, data word width.
REQ-002 SHALL have parameter CHANNELS, default 8, number of input channels (2..16).
REQ-003 SHALL derive SEL_BITS = ceil(log2(CHANNELS)), not overridable.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port datoIn, input, CHANNELS*BITS, packed channel data; channel k occupies bits [k*BITS +: BITS].
REQ-007 SHALL have port validIn, input, CHANNELS, per-channel valid.
REQ-008 SHALL have port readyOut, output, CHANNELS, per-channel ready; channel k transfers when validIn[k] and readyOut[k] are both 1.
REQ-009 SHALL have port selMode, input, 1: 0 = direct select, 1 = round-robin.
REQ-010 SHALL have port selDato, input, SEL_BITS, channel index used in direct-select mode.
REQ-011 SHALL have port datoOutput, output, BITS, registered output word.
REQ-012 SHALL have port validOutput, output, 1, output word valid.
REQ-013 SHALL have port readyInput, input, 1, downstream ready; output transfer when validOutput and readyInput are both 1.
REQ-014 SHALL have port grantOutput, output, SEL_BITS, index of the channel that supplied the current datoOutput.

Function
REQ-015 SHALL accept a new word ("accept") when validOutput=0 or readyInput=1, so throughput is one word per cycle.
REQ-016 SHALL in direct mode nominate channel selDato if validIn[selDato]=1; no nomination if selDato >= CHANNELS.
REQ-017 SHALL in round-robin mode nominate the first channel with validIn=1, scanning upward from pointer rrPtr with wrap from CHANNELS-1 to 0.
REQ-018 SHALL drive readyOut[k]=1 only when accept=1 and k is the nominee; all other bits 0; at most one bit set (one-hot or zero).
REQ-019 SHALL be combinational from validIn/selDato/selMode/readyInput to readyOut; readyOut SHALL NOT depend on datoIn.
REQ-020 SHALL on transfer load datoOutput <= nominee data, grantOutput <= nominee index, validOutput <= 1 on the next edge; latency exactly 1 cycle.
REQ-021 SHALL on accept with no nominee set validOutput <= 0 and hold datoOutput and grantOutput.
REQ-022 SHALL hold datoOutput, grantOutput and validOutput stable while validOutput=1 and readyInput=0.
REQ-023 SHALL in round-robin mode, after a transfer from channel k, set rrPtr <= (k+1) mod CHANNELS; rrPtr holds otherwise, including all direct-mode cycles.
REQ-024 SHALL apply a selMode or selDato change to the next nomination only; a held output word is unaffected.
REQ-025 SHALL accept a simultaneous output transfer and input transfer in the same cycle without a bubble.

Reset
REQ-026 SHALL while reset=1 at an edge set validOutput=0, datoOutput=0, grantOutput=0, rrPtr=0.
REQ-027 SHALL force readyOut to all-zero while reset=1, so no input transfer occurs during reset.
REQ-028 SHALL discard a held word if reset is asserted mid-stall; that word is not replayed.

Structure
REQ-029 SHALL place the mode enum (MODE_SELECT=0, MODE_ROUND_ROBIN=1) and the default BITS/CHANNELS constants in shared package mux_pkg.
REQ-030 SHALL implement round-robin nomination in sub-module rr_picker: inputs request vector and pointer; outputs found flag and index; purely combinational.
REQ-031 SHALL keep all registers in mux_arbiter; rr_picker holds no state.

Verification
REQ-032 Direct mode, CHANNELS=8, selDato=5, validIn=8'hFF, datoIn ch5=32'hA5A5_0005, readyInput=1 -> readyOut=8'h20; next cycle datoOutput=32'hA5A5_0005, grantOutput=5, validOutput=1.
REQ-033 Round-robin, validIn=8'hFF held, readyInput=1 for 10 cycles after reset -> grantOutput sequence 0,1,...,7,0,1.
REQ-034 Round-robin, validIn=8'b1000_0001, rrPtr=1 -> grant 7, then 0, then 7 (wrap).
REQ-035 Output stall: validOutput=1 with word 32'h1234, readyInput=0 for 3 cycles -> readyOut=0, datoOutput stays 32'h1234; readyInput=1 -> next word loads the following cycle.
REQ-036 CHANNELS=6, direct mode, selDato=7, validIn=6'h3F -> readyOut=0, validOutput falls to 0.
REQ-037 Reset asserted mid-stall with valid word -> next cycle validOutput=0, datoOutput=0, grantOutput=0; first round-robin grant after reset is channel 0.
